filter_xfade_ctrl: RTL
======================

# filter_xfade_ctrl

Click-free path selector and crossfade controller for the audio filter chain. It replaces the bare bypass/FIR/IIR multiplexer ahead of the I2S transmitter. It debounces the slide-switch path request, ramps the active path's gain to zero, switches paths, and ramps back to unity. All gain updates are paced by the per-sample `new_data` strobe.

## Interface
- `RAMP_LOG2`, default 6: log2 of ramp length; gain runs 0..2^RAMP_LOG2 (64 samples).
- `DEB_SAMPLES`, default 4: consecutive sample strobes a request must be stable before it is accepted (≥1).
- `clk` in 1: bit clock domain (AUD_BCLK); the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `new_data` in 1: one-`clk` pulse per audio sample frame.
- `sel` in 2: raw path request from switches, asynchronous; 00 = bypass, 01 = FIR, 10 = IIR, 11 treated as 00.
- `x_bypass`, `x_fir`, `x_iir` in 16 signed: path samples, valid on the `new_data` cycle.
- `y_out` out 16 signed: gained sample of the active path.
- `active_sel` out 2: path currently routed (never 11).
- `gain` out RAMP_LOG2+1: current gain g.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- **Synchronizer:** `sel` passes through a 2-flop synchronizer on `clk`; 11 is mapped to 00 after synchronization.
- **Debounce:** evaluated only on `new_data` cycles, using registers `cand` and `cnt`.
  - If the synced value ≠ `cand`: `cand` ← synced value, `cnt` ← 1. This strobe counts as the first.
  - Otherwise `cnt` increments, saturating at DEB_SAMPLES.
  - `stable_sel` ← `cand` on the strobe where `cnt` reaches DEB_SAMPLES.
  - With DEB_SAMPLES = 1, `stable_sel` follows the synced value on every strobe.
- **Datapath:** on each `new_data` cycle:
  - `y_out` ← (x_active × g) >>> RAMP_LOG2, using a signed 16 × (RAMP_LOG2+2) multiply, arithmetic shift, truncated to 16 bits.
  - g ≤ 2^RAMP_LOG2, so no overflow occurs. g = 2^RAMP_LOG2 gives exactly x; g = 0 gives 0.
  - The g and `active_sel` used are the values before this strobe's FSM update.
- **FSM:** transitions occur only on `new_data` cycles; state is held otherwise.
  - **IDLE** (g = 2^RAMP_LOG2): if `stable_sel` ≠ `active_sel`, go to FADE_OUT and set g ← g−1.
  - **FADE_OUT**, checked in this order:
    - If `stable_sel` = `active_sel` (request reverted): go to FADE_IN, g ← g+1.
    - Else if g = 0: `active_sel` ← `stable_sel`, go to FADE_IN, g unchanged.
    - Else g ← g−1.
  - **FADE_IN**, checked in this order:
    - If `stable_sel` ≠ `active_sel`: go to FADE_OUT, g ← g−1. The ramp reverses from the current g; no jump.
    - Else if g = 2^RAMP_LOG2: go to IDLE.
    - Else g ← g+1.
- **Mid-fade request changes:** a request that changes during FADE_OUT is adopted at the g = 0 strobe using the latest `stable_sel`. Only one path switch occurs per zero crossing.

## Timing
- **Reset values:** `y_out` = 0, `active_sel` = 00, g = 2^RAMP_LOG2, state IDLE, `busy` = 0, `cand` = 00, `cnt` = DEB_SAMPLES, `stable_sel` = 00, synchronizer flops = 00.
- **Reset mid-fade:** output returns immediately (asynchronously) to the reset values; no ramp is resumed.
- **`y_out` latency:** updated at the `clk` edge that samples `new_data` = 1, i.e. one `clk` latency. It is held constant between strobes.
- **Request latency:** after a `sel` change, `stable_sel` changes on the DEB_SAMPLES-th strobe that sees the synced value. The FSM reacts on the following strobe.
- **Full switch duration:** from the IDLE decision strobe, a switch takes 2·2^RAMP_LOG2 + 2 strobes to return to IDLE (130 at defaults). `busy` rises after the first strobe and falls after the last.
- **Consecutive strobes:** `new_data` pulses on consecutive `clk` cycles are each processed; no minimum spacing is required.

## Test plan
- **Reset:** `rst_n` = 0 mid-fade (g = 20), released → `y_out` = 0, `active_sel` = 00, g = 64, `busy` = 0. First strobe with `x_bypass` = 1000 → `y_out` = 1000.
- **Full switch:** defaults, `x_bypass` = 1000, `x_fir` = −2000, `sel` 00→01 → `stable_sel` changes on the 4th strobe. Then:
  - `y_out` sequence 1000, 984, …, 15, 0 (bypass), then 0, −32, …, −2000 (FIR).
  - `busy` high for exactly 130 strobes; `active_sel` = 01 from the zero strobe.
- **Reversal:** during FADE_OUT at g = 30, `sel` returns to 00 and is held → g ramps 30→64 without a switch; `active_sel` stays 00.
- **Retarget:** `sel` 00→01, then 01→10 before g reaches 0 → a single switch directly to 10 at g = 0; path 01 is never routed.
- **Debounce:** `sel` toggles 00↔01 every 2 strobes → `stable_sel` stays 00, `busy` stays 0. Also `sel` = 11 held → no transition.
- **Extremes:** `x_iir` = −32768 at g = 64 → `y_out` = −32768; at g = 32 → −16384; with DEB_SAMPLES = 1 the FSM reacts on the 2nd strobe after the change.

Source files
------------

// File: rtl/filter_xfade_ctrl.sv
// Click-free path selector: debounces the path request, fades the active path to zero, switches, fades back in.
// Latency: y_out updates one clk after new_data; all state advances only on new_data strobes.
module filter_xfade_ctrl #(
    parameter int RAMP_LOG2   = 6,
    parameter int DEB_SAMPLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_data,
    input  logic [1:0]              sel,
    input  logic signed [15:0]      x_bypass,
    input  logic signed [15:0]      x_fir,
    input  logic signed [15:0]      x_iir,
    output logic signed [15:0]      y_out,
    output logic [1:0]              active_sel,
    output logic [RAMP_LOG2:0]      gain,
    output logic                    busy
);
    localparam int GW = RAMP_LOG2 + 1;
    localparam int PW = 16 + RAMP_LOG2 + 2;
    localparam int CW = $clog2(DEB_SAMPLES + 1);
    localparam logic [GW-1:0] G_MAX   = GW'(1 << RAMP_LOG2);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_SAMPLES);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;

    state_t            state, state_nxt;
    logic [1:0]        sync_q1, sync_q2, synced;
    logic [1:0]        cand, cand_nxt, stable_sel;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [GW-1:0]     gain_nxt;
    logic [1:0]        active_nxt;
    logic signed [15:0]   x_act;
    logic signed [PW-1:0] gain_ext, prod;

    // "11" is an illegal switch combination and selects bypass
    assign synced = (sync_q2 == 2'b11) ? 2'b00 : sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= sel;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (synced != cand) begin
            cand_nxt = synced;
            cnt_nxt  = CW'(1);
        end else if (cnt != DEB_MAX) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= 2'b00;
            cnt        <= DEB_MAX;
            stable_sel <= 2'b00;
        end else if (new_data) begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
            if (cnt_nxt == DEB_MAX) begin
                stable_sel <= cand_nxt;
            end
        end
    end

    // FSM sees stable_sel from before this strobe's debounce update
    always_comb begin
        state_nxt  = state;
        gain_nxt   = gain;
        active_nxt = active_sel;
        unique case (state)
            IDLE: begin
                if (stable_sel != active_sel) begin
                    state_nxt = FADE_OUT;
                    gain_nxt  = gain - GW'(1);
                end
            end
            FADE_OUT: begin
                if (stable_sel == active_sel) begin
                    state_nxt = FADE_IN;
                    gain_nxt  = gain + GW'(1);
                end else if (gain == '0) begin
                    active_nxt = stable_sel;
                    state_nxt  = FADE_IN;
                end else begin
                    gain_nxt = gain - GW'(1);
                end
            end
            FADE_IN: begin
                if (stable_sel != active_sel) begin
                    state_nxt = FADE_OUT;
                    gain_nxt  = gain - GW'(1);
                end else if (gain == G_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    gain_nxt = gain + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (active_sel)
            2'b01:   x_act = x_fir;
            2'b10:   x_act = x_iir;
            default: x_act = x_bypass;
        endcase
    end

    assign gain_ext = PW'(gain);
    assign prod     = PW'(x_act) * gain_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gain       <= G_MAX;
            active_sel <= 2'b00;
            y_out      <= '0;
        end else if (new_data) begin
            state      <= state_nxt;
            gain       <= gain_nxt;
            active_sel <= active_nxt;
            y_out      <= 16'(prod >>> RAMP_LOG2);
        end
    end

    assign busy = (state != IDLE);

endmodule
